// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
//   Shared definitions for the PLL lock sequencer:
//     - pll_seq_state_t : sequencer state encoding (3 bits, exported on `state`)
//     - RETRY_W         : width of the retry counter
//     - cnt_width()     : width of the single shared cycle counter, i.e. clog2
//                         of the largest of the four cycle-count parameters
// -----------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_seq_state_t;

    localparam int RETRY_W = 3;

    // The counter must hold every terminal value (N-1) of every phase, so
    // clog2 of the largest count is enough; never let the width collapse to 0.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// -----------------------------------------------------------------------------
// pll_lock_sync
//   Two-flop synchronizer bringing the PLL's asynchronous `locked` output into
//   the refclk domain. Both flops clear asynchronously so a reset never lets a
//   stale lock indication through.
//
// Ports:
//   refclk   in  1  destination clock
//   rst_n    in  1  asynchronous active-low clear
//   async_in in  1  asynchronous input (PLL locked)
//   sync_out out 1  synchronized level, two refclk cycles of latency
// -----------------------------------------------------------------------------
module pll_lock_sync (
    input  logic refclk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//   Sequences the board PLL from refclk: holds it in reset, waits for lock with
//   a timeout, qualifies lock stability, then raises `sys_ready`. Lock loss in
//   RUN re-sequences the PLL; repeated lock timeouts end in FAULT. A held
//   `relock_req` is accepted in RUN or FAULT with a one-cycle `relock_ack`.
//
// Build option:
//   PLL_SEQ_LOSS_FILTER_EN - when defined, lock loss in RUN is declared only
//   after LOSS_FILTER consecutive unlocked cycles; otherwise a single unlocked
//   cycle declares loss.
//
// Ports:
//   refclk     in  1  PLL reference clock, sole clock of this block
//   rst_n      in  1  asynchronous active-low reset
//   pll_locked in  1  PLL locked, asynchronous to refclk
//   relock_req in  1  request a full re-sequence, held until relock_ack
//   pll_rst    out 1  PLL reset, active high (asserts asynchronously on reset)
//   relock_ack out 1  one-cycle pulse, relock request accepted
//   sys_ready  out 1  high only in RUN
//   fault      out 1  high in FAULT
//   state      out 3  current state encoding
//   retry_cnt  out 3  lock timeouts since last relock/reset, saturating
// -----------------------------------------------------------------------------
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int LOSS_FILTER   = 4
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               relock_ack,
    output logic               sys_ready,
    output logic               fault,
    output logic [2:0]         state,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, LOSS_FILTER);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_SEQ_LOSS_FILTER_EN
    localparam logic [CNT_W-1:0]   LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
`endif
    localparam logic [RETRY_W-1:0] RETRY_SAT    = '1;

    pll_seq_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_d, retry_inc;
    logic               ack_d;
    logic               lock_s;

    pll_lock_sync u_lock_sync (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .async_in (pll_locked),
        .sync_out (lock_s)
    );

    assign retry_inc = (retry_cnt == RETRY_SAT) ? retry_cnt : retry_cnt + 1'b1;
    assign state     = state_q;

    // Next-state, counter and retry logic. A relock request outranks lock
    // loss in RUN; both go to RESET_PLL, but only the request acks and
    // clears the retry count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_cnt;
        ack_d   = 1'b0;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    if (MAX_RETRIES != 0 && int'(retry_inc) >= MAX_RETRIES)
                        state_d = ST_FAULT;
                    else
                        state_d = ST_RESET_PLL;
                end
            end
            ST_STABLE: begin
                if (!lock_s)                   state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (relock_req) begin
                    ack_d   = 1'b1;
                    retry_d = '0;
                    state_d = ST_RESET_PLL;
                end else begin
`ifdef PLL_SEQ_LOSS_FILTER_EN
                    // The counter doubles as the run of consecutive unlocked cycles.
                    if (lock_s)                  cnt_d   = '0;
                    else if (cnt_q == LOSS_LAST) state_d = ST_RESET_PLL;
`else
                    if (!lock_s) state_d = ST_RESET_PLL;
`endif
                end
            end
            ST_FAULT: begin
                if (relock_req) begin
                    ack_d   = 1'b1;
                    retry_d = '0;
                    state_d = ST_RESET_PLL;
                end
            end
            default: state_d = ST_RESET_PLL;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    // State, counter and registered outputs. Outputs are decoded from the
    // next state so they line up with the registered state every cycle.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET_PLL;
            cnt_q      <= '0;
            retry_cnt  <= '0;
            pll_rst    <= 1'b1;
            sys_ready  <= 1'b0;
            fault      <= 1'b0;
            relock_ack <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_cnt  <= retry_d;
            pll_rst    <= (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
            sys_ready  <= (state_d == ST_RUN);
            fault      <= (state_d == ST_FAULT);
            relock_ack <= ack_d;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Self-checking bench for pll_lock_sequencer with small parameters. A
//   table of {inputs, cycles, expected outputs} records walks the main
//   sequences; a hand-written block exercises a mid-cycle asynchronous reset;
//   a randomized phase runs against a phase/elapsed-time reference model.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int LOSS_FILTER   = 3;

    localparam int P_RESET  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, relock_ack, sys_ready, fault;
    logic [2:0] state, retry_cnt;

    int vectors = 0;
    int miscompares = 0;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .LOSS_FILTER   (LOSS_FILTER)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .relock_ack (relock_ack),
        .sys_ready  (sys_ready),
        .fault      (fault),
        .state      (state),
        .retry_cnt  (retry_cnt)
    );

    // 50 MHz reference clock
    always #10 refclk = ~refclk;

    // Reference model: phase plus cycles spent in it, a retry tally, a run of
    // unlocked cycles in RUN, and a history of sampled pll_locked values
    // (the synchronized view is the sample taken two edges earlier).
    int m_phase, m_elapsed, m_retries, m_loss;
    bit m_ack;
    bit lock_hist[$];

    function automatic void model_reset();
        m_phase   = P_RESET;
        m_elapsed = 0;
        m_retries = 0;
        m_loss    = 0;
        m_ack     = 1'b0;
        lock_hist.delete();
    endfunction

    function automatic void model_step(input bit req, input bit locked);
        bit lock_seen;
        int next;
        lock_seen = (lock_hist.size() >= 2) ? lock_hist[lock_hist.size()-2] : 1'b0;
        lock_hist.push_back(locked);
        if (lock_hist.size() > 4) void'(lock_hist.pop_front());
        next  = m_phase;
        m_ack = 1'b0;
        m_elapsed++;
        case (m_phase)
            P_RESET:  if (m_elapsed == RST_CYCLES) next = P_WAIT;
            P_WAIT: begin
                if (lock_seen) next = P_STABLE;
                else if (m_elapsed == LOCK_TIMEOUT) begin
                    if (m_retries < 7) m_retries++;
                    next = (MAX_RETRIES != 0 && m_retries >= MAX_RETRIES) ? P_FAULT : P_RESET;
                end
            end
            P_STABLE: begin
                if (!lock_seen) next = P_WAIT;
                else if (m_elapsed == STABLE_CYCLES) next = P_RUN;
            end
            P_RUN: begin
                if (req) begin
                    m_ack = 1'b1; m_retries = 0; next = P_RESET;
                end else begin
`ifdef PLL_SEQ_LOSS_FILTER_EN
                    m_loss = lock_seen ? 0 : m_loss + 1;
                    if (m_loss == LOSS_FILTER) next = P_RESET;
`else
                    if (!lock_seen) next = P_RESET;
`endif
                end
            end
            default: if (req) begin
                m_ack = 1'b1; m_retries = 0; next = P_RESET;
            end
        endcase
        if (next != m_phase) begin
            m_phase   = next;
            m_elapsed = 0;
            m_loss    = 0;
        end
    endfunction

    function automatic logic [9:0] model_expect();
        return {3'(m_phase),
                (m_phase == P_RESET) || (m_phase == P_FAULT),
                (m_phase == P_RUN),
                (m_phase == P_FAULT),
                m_ack,
                3'(m_retries)};
    endfunction

    // Output bundle order: state, pll_rst, sys_ready, fault, relock_ack, retry_cnt
    task automatic checkOutput(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {state, pll_rst, sys_ready, fault, relock_ack, retry_cnt};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got state=%0d pll_rst=%0b sys_ready=%0b fault=%0b ack=%0b retry=%0d, expected state=%0d pll_rst=%0b sys_ready=%0b fault=%0b ack=%0b retry=%0d",
                     name, $time, act[9:7], act[6], act[5], act[4], act[3], act[2:0],
                     exp[9:7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    // Drive inputs on the falling edge, advance the model on the rising edge,
    // then compare each cycle against the model.
    task automatic applyStimulus(input bit rn, input bit lk, input bit rq, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge refclk);
            rst_n      = rn;
            pll_locked = lk;
            relock_req = rq;
            if (!rn) model_reset();
            @(posedge refclk);
            if (rst_n) model_step(relock_req, pll_locked);
            #1;
            checkOutput("model", model_expect());
        end
    endtask

    typedef struct {
        bit         rn;
        bit         lk;
        bit         rq;
        int         n;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit rn, input bit lk, input bit rq, input int n,
                                input logic [2:0] st, input bit prst, input bit rdy,
                                input bit flt, input bit ack, input logic [2:0] rty);
        vec_t v;
        v.rn = rn; v.lk = lk; v.rq = rq; v.n = n;
        v.exp = {st, prst, rdy, flt, ack, rty};
        tbl.push_back(v);
    endfunction

    initial begin
        model_reset();

        // Power-up: pll_rst held 4 cycles, lock raised 10 cycles after it falls
        add(0, 0, 0,  2, 3'd0, 1, 0, 0, 0, 3'd0);
        add(1, 0, 0,  3, 3'd0, 1, 0, 0, 0, 3'd0);
        add(1, 0, 0,  1, 3'd1, 0, 0, 0, 0, 3'd0);
        add(1, 0, 0,  9, 3'd1, 0, 0, 0, 0, 3'd0);
        add(1, 1, 0,  2, 3'd1, 0, 0, 0, 0, 3'd0);
        add(1, 1, 0,  1, 3'd2, 0, 0, 0, 0, 3'd0);
        add(1, 1, 0,  7, 3'd2, 0, 0, 0, 0, 3'd0);
        add(1, 1, 0,  1, 3'd3, 0, 1, 0, 0, 3'd0);
        add(1, 1, 0,  5, 3'd3, 0, 1, 0, 0, 3'd0);
        // Single-cycle lock drop in RUN
        add(1, 0, 0,  1, 3'd3, 0, 1, 0, 0, 3'd0);
        add(1, 1, 0,  1, 3'd3, 0, 1, 0, 0, 3'd0);
`ifdef PLL_SEQ_LOSS_FILTER_EN
        add(1, 1, 0,  1, 3'd3, 0, 1, 0, 0, 3'd0);
        add(1, 0, 0,  3, 3'd3, 0, 1, 0, 0, 3'd0);
        add(1, 1, 0,  1, 3'd3, 0, 1, 0, 0, 3'd0);
        add(1, 1, 0,  1, 3'd0, 1, 0, 0, 0, 3'd0);
`else
        add(1, 1, 0,  1, 3'd0, 1, 0, 0, 0, 3'd0);
`endif
        // One timeout, then lock drops at STABLE cycle 5 and qualification restarts
        add(0, 0, 0,  2, 3'd0, 1, 0, 0, 0, 3'd0);
        add(1, 0, 0, 36, 3'd0, 1, 0, 0, 0, 3'd1);
        add(1, 1, 0,  8, 3'd2, 0, 0, 0, 0, 3'd1);
        add(1, 0, 0,  1, 3'd2, 0, 0, 0, 0, 3'd1);
        add(1, 1, 0,  1, 3'd2, 0, 0, 0, 0, 3'd1);
        add(1, 1, 0,  1, 3'd1, 0, 0, 0, 0, 3'd1);
        add(1, 1, 0,  1, 3'd2, 0, 0, 0, 0, 3'd1);
        add(1, 1, 0,  7, 3'd2, 0, 0, 0, 0, 3'd1);
        add(1, 1, 0,  1, 3'd3, 0, 1, 0, 0, 3'd1);
        // Lock never arrives: two windows then FAULT
        add(0, 0, 0,  2, 3'd0, 1, 0, 0, 0, 3'd0);
        add(1, 0, 0, 35, 3'd1, 0, 0, 0, 0, 3'd0);
        add(1, 0, 0,  1, 3'd0, 1, 0, 0, 0, 3'd1);
        add(1, 0, 0,  3, 3'd0, 1, 0, 0, 0, 3'd1);
        add(1, 0, 0,  1, 3'd1, 0, 0, 0, 0, 3'd1);
        add(1, 0, 0, 31, 3'd1, 0, 0, 0, 0, 3'd1);
        add(1, 0, 0,  1, 3'd4, 1, 0, 1, 0, 3'd2);
        add(1, 0, 0, 20, 3'd4, 1, 0, 1, 0, 3'd2);
        // Relock out of FAULT, then lock reaches RUN
        add(1, 0, 1,  1, 3'd0, 1, 0, 0, 1, 3'd0);
        add(1, 1, 0, 12, 3'd2, 0, 0, 0, 0, 3'd0);
        add(1, 1, 0,  1, 3'd3, 0, 1, 0, 0, 3'd0);
        // Relock from RUN: single ack pulse
        add(1, 1, 1,  1, 3'd0, 1, 0, 0, 1, 3'd0);
        add(1, 1, 0,  1, 3'd0, 1, 0, 0, 0, 3'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rn, tbl[i].lk, tbl[i].rq, tbl[i].n);
            checkOutput($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Asynchronous reset mid-cycle while in WAIT_LOCK with lock toggling
        applyStimulus(0, 0, 0, 2);
        applyStimulus(1, 0, 0, 4);
        checkOutput("wait_entry", {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        for (int i = 0; i < 3; i++) applyStimulus(1, (i % 2) == 0, 0, 1);
        @(posedge refclk);
        #3;
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        #1;
        checkOutput("async_rst", {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
        model_reset();
        applyStimulus(0, 1, 0, 2);
        applyStimulus(1, 1, 0, 3);
        checkOutput("reseq_rst", {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
        applyStimulus(1, 1, 0, 1);
        checkOutput("reseq_wait", {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
        applyStimulus(1, 1, 0, 1);
        checkOutput("reseq_stable", {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});

        // Randomized segments of lock/unlock, sporadic relock requests and resets
        begin
            int seg_left;
            bit seg_val;
            bit req;
            bit rn;
            seg_left = 0;
            seg_val  = 1'b0;
            req      = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if (seg_left == 0) begin
                    seg_val = ($urandom_range(0, 3) != 0);
                    if (seg_val)                         seg_left = int'($urandom_range(1, 60));
                    else if ($urandom_range(0, 3) == 0)  seg_left = int'($urandom_range(30, 80));
                    else                                 seg_left = int'($urandom_range(1, 4));
                end
                seg_left--;
                if (m_ack)                                  req = 1'b0;
                else if (!req && $urandom_range(0, 99) < 2) req = 1'b1;
                rn = ($urandom_range(0, 499) != 0);
                applyStimulus(rn, seg_val, req, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controller for the board PLL macro (refclk in, rst/locked handshake, single outclk).
- Runs in the refclk domain (50 MHz).
- Sequences the PLL: holds it in reset, waits for lock with a timeout, qualifies lock stability, then releases a `sys_ready` qualifier for the fabric running on outclk.
- Detects lock loss, retries a bounded number of times, and accepts software/top-level relock requests.

Parameters:
- RST_CYCLES, 16, refclk cycles `pll_rst` is held high per reset attempt (min 1).
- LOCK_TIMEOUT, 65536, refclk cycles to wait for lock after `pll_rst` release before retrying (min 2).
- STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before RUN (min 1).
- MAX_RETRIES, 7, lock timeouts tolerated before FAULT; 0 = retry forever.
- LOSS_FILTER, 4, consecutive lock-low cycles needed to declare loss in RUN (only with macro).

Ports:
- refclk  in  1  PLL reference clock; sole clock of this block.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked output, asynchronous to refclk.
- relock_req  in  1  request a full PLL re-sequence; held until `relock_ack`.
- pll_rst  out  1  drives PLL rst, active high.
- relock_ack  out  1  one-cycle pulse, `relock_req` accepted.
- sys_ready  out  1  high only in RUN; downstream synchronizes into outclk domain.
- fault  out  1  high in FAULT.
- state  out  3  current state encoding.
- retry_cnt  out  3  lock timeouts since last accepted relock/reset, saturates at 7.

Behaviour:
- Reset (`rst_n`=0, async): state=RESET_PLL, `pll_rst`=1, `sys_ready`=0, `fault`=0, `relock_ack`=0, `retry_cnt`=0, cycle counter=0, synchronizer flops=0. Outputs are registered.
- `pll_locked` passes through a 2-flop synchronizer → `lock_s`, giving 2 cycles of latency. Only `lock_s` is used.
- One shared counter; width = clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, LOSS_FILTER). It is cleared on every state transition.
- Encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- RESET_PLL:
  - `pll_rst`=1.
  - When cnt==RST_CYCLES-1 → WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0.
  - If `lock_s` → STABLE.
  - Else if cnt==LOCK_TIMEOUT-1: `retry_cnt`++ (saturating). If MAX_RETRIES≠0 and the incremented count ≥ MAX_RETRIES → FAULT, else → RESET_PLL.
- STABLE:
  - `pll_rst`=0.
  - `lock_s`=0 → WAIT_LOCK (no `retry_cnt` change; timeout restarts).
  - cnt==STABLE_CYCLES-1 with `lock_s`=1 → RUN.
- RUN:
  - `sys_ready`=1 from the first cycle registered in RUN.
  - Lock loss → RESET_PLL; `sys_ready` deasserts the cycle state leaves RUN.
  - `retry_cnt` is not cleared on entering RUN.
- FAULT:
  - `pll_rst`=1 and `fault`=1, held indefinitely.
  - Exit only via `relock_req` or `rst_n`.
- `relock_req` handling:
  - Sampled only in RUN and FAULT; ignored elsewhere. A held request is accepted upon reaching RUN.
  - Acceptance: `relock_ack`=1 for exactly one cycle, `retry_cnt` cleared, next state RESET_PLL.
  - The requester must drop `relock_req` the cycle after `relock_ack`. A request still high one cycle after ack counts as a new request.
- Simultaneous lock loss and `relock_req` in RUN: the request wins (ack issued, `retry_cnt` cleared); destination is RESET_PLL either way.
- `pll_locked` glitching during RESET_PLL is ignored.
- `rst_n` asserted mid-sequence returns immediately to reset values. `pll_rst` asserts asynchronously.

Optional Feature:
- PLL_SEQ_LOSS_FILTER_EN defined: in RUN, loss is declared only after LOSS_FILTER consecutive `lock_s`=0 cycles. The counter is reused and reset by any `lock_s`=1 cycle; `sys_ready` stays 1 during filtering.
- Undefined: a single `lock_s`=0 cycle in RUN declares loss. LOSS_FILTER is unused.

Decomposition:
- Package `pll_seq_pkg`:
  - state enum (3-bit, values above)
  - RETRY_W=3 constant
  - counter-width function (clog2 of max)
- Sub-module `pll_lock_sync`: 2-flop synchronizer with async active-low clear. It is the only natural split; the FSM and counter stay in the top block.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2, LOSS_FILTER=3):
- Release `rst_n`, raise `pll_locked` 10 cycles after `pll_rst` falls → `pll_rst` high exactly 4 cycles; `sys_ready` rises 2+8 cycles after lock; `retry_cnt`=0.
- `pll_locked` never asserts → two 32-cycle WAIT_LOCK windows separated by a 4-cycle reset; then state=4, `fault`=1, `retry_cnt`=2, `pll_rst` stuck high.
- In FAULT, pulse `relock_req` → `relock_ack` for 1 cycle, `retry_cnt`=0, state=0; lock applied → reaches RUN.
- In RUN, drop `pll_locked` for 1 cycle → without macro: `sys_ready` falls and state=0. With macro: no change. A 3-cycle drop → loss declared.
- Lock drops at STABLE cycle 5 → WAIT_LOCK, `retry_cnt` unchanged, full 8-cycle qualification restarts.
- Assert `rst_n`=0 during WAIT_LOCK with lock toggling → `pll_rst`=1 asynchronously, all outputs at reset values; re-sequence from RESET_PLL.
